// File: rtl/spi_slave_array_if.sv
// Bus bundle for spi_slave_array: SPI pins, frame configuration and per-channel
// receive results, with slave (DUT) and master (driver) views.
interface spi_slave_array_if #(
    parameter int CH = 2
);
    logic              SPI_SCLK;
    logic              MOSI;
    logic              MISO;
    logic [CH-1:0]     CS;
    logic [1:0]        transaction_length;
    logic              CPOL;
    logic              CPHA;
    logic [CH*32-1:0]  tx_data;
    logic [CH*32-1:0]  rx_data;
    logic [CH-1:0]     rx_valid;
    logic              busy;
    logic              abort;
    logic              collision;

    modport slave (
        input  SPI_SCLK, MOSI, CS, transaction_length, CPOL, CPHA, tx_data,
        output MISO, rx_data, rx_valid, busy, abort, collision
    );

    modport master (
        output SPI_SCLK, MOSI, CS, transaction_length, CPOL, CPHA, tx_data,
        input  MISO, rx_data, rx_valid, busy, abort, collision
    );
endinterface

// File: rtl/spi_slave_array.sv
// Multi-channel SPI slave oversampled on clk: one shared shifter serves whichever
// single chip select is asserted; frame length and SPI mode are latched per frame.
module spi_slave_array #(
    parameter int CH          = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic              clk,
    input logic              rst,
    spi_slave_array_if.slave bus
);
    localparam int IW = (CH > 1) ? $clog2(CH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                         state_q, state_d;
    logic [SYNC_STAGES-1:0]         sclk_sync_q;
    logic [SYNC_STAGES-1:0]         mosi_sync_q;
    logic [SYNC_STAGES-1:0][CH-1:0] cs_sync_q;
    logic                           sclk_prev_q;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [5:0]                     len_bits_q, len_bits_d;
    logic                           cpol_q, cpol_d;
    logic                           cpha_q, cpha_d;
    logic [5:0]                     cnt_q, cnt_d;
    logic [31:0]                    tx_q, tx_d;
    logic [31:0]                    rx_q, rx_d;
    logic [CH*32-1:0]               rx_data_q, rx_data_d;
    logic [CH-1:0]                  rx_valid_q, rx_valid_d;
    logic                           abort_q, abort_d;

    logic          sclk_s, mosi_s;
    logic [CH-1:0] cs_s;
    logic [3:0]    low_cnt;
    logic [IW-1:0] low_idx;
    logic          collision;
    logic          sclk_edge, lead, trail, sample_edge, shift_edge;
    logic [5:0]    start_bits;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= {SYNC_STAGES{bus.CPOL}};
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            sclk_prev_q <= bus.CPOL;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.SPI_SCLK};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.MOSI};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.CS};
            sclk_prev_q <= sclk_s;
        end
    end

    always_comb begin
        low_cnt = '0;
        low_idx = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (!cs_s[i]) begin
                low_cnt = low_cnt + 4'd1;
                low_idx = IW'(i);
            end
        end
    end

    assign collision  = (low_cnt > 4'd1);
    assign start_bits = 6'({bus.transaction_length, 3'b000}) + 6'd8;

    // Edge polarity is judged against the latched CPOL, never the live input.
    assign sclk_edge   = (sclk_s != sclk_prev_q);
    assign lead        = sclk_edge && (sclk_prev_q == cpol_q);
    assign trail       = sclk_edge && (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail : lead;
    assign shift_edge  = cpha_q ? (lead && (cnt_q != '0)) : trail;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        len_bits_d = len_bits_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = '0;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (low_cnt == 4'd1) begin
                    state_d    = SHIFT;
                    idx_d      = low_idx;
                    len_bits_d = start_bits;
                    cpol_d     = bus.CPOL;
                    cpha_d     = bus.CPHA;
                    cnt_d      = '0;
                    rx_d       = '0;
                    // Left-align the L-bit word so the next MISO bit is always bit 31.
                    tx_d       = bus.tx_data[32*low_idx +: 32] << (6'd32 - start_bits);
                end
            end
            SHIFT: begin
                if (collision) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (cnt_q == len_bits_q) begin
                    state_d                   = DONE;
                    rx_valid_d[idx_q]         = 1'b1;
                    rx_data_d[32*idx_q +: 32] = rx_q;
                end else if (cs_s[idx_q]) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else begin
                    if (sample_edge) begin
                        rx_d  = {rx_q[30:0], mosi_s};
                        cnt_d = cnt_q + 6'd1;
                    end
                    if (shift_edge) begin
                        tx_d = {tx_q[30:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (cs_s[idx_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            len_bits_q <= 6'd8;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            len_bits_q <= len_bits_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.MISO      = ((state_q == SHIFT) && !collision) ? tx_q[31] : 1'b0;
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.abort     = abort_q;
    assign bus.collision = collision;
endmodule

// File: tb/tb_spi_slave_array.sv
// Directed bench for spi_slave_array: a table of complete frames in all four SPI
// modes plus hand-written abort, collision, reset and over-clocking sequences.
module tb_spi_slave_array;
    localparam int CH = 2;
    localparam int H  = 6;

    typedef struct {
        int          ch;
        logic [1:0]  len;
        logic        cpol;
        logic        cpha;
        logic [31:0] mosi;
        logic [31:0] tx;
        logic [31:0] exp_rx;
        logic [31:0] exp_miso;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_array_if #(.CH(CH)) bus ();

    spi_slave_array #(.CH(CH), .SYNC_STAGES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int rv0 = 0, rv1 = 0, abc = 0;
    int s0, s1, sa;
    logic [31:0] exp_rx [CH];
    logic [31:0] sw;
    vec_t tbl [4];

    always @(negedge clk) begin
        if (bus.rx_valid[0]) rv0 <= rv0 + 1;
        if (bus.rx_valid[1]) rv1 <= rv1 + 1;
        if (bus.abort)       abc <= abc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s0 = rv0;
        s1 = rv1;
        sa = abc;
    endtask

    task automatic setup(input logic cpol, input logic cpha, input logic [1:0] len,
                         input logic [31:0] tx0, input logic [31:0] tx1);
        bus.CPOL               = cpol;
        bus.CPHA               = cpha;
        bus.transaction_length = len;
        bus.tx_data            = {tx1, tx0};
        bus.SPI_SCLK           = cpol;
        bus.MOSI               = 1'b0;
        wclk(4);
    endtask

    // Clocks nb bits as an SPI master; bits past L drive MOSI high, MISO kept for first L.
    task automatic xfer(input logic cpol, input logic cpha, input int L, input int nb,
                        input logic [31:0] mw, output logic [31:0] miso_w);
        logic b;
        miso_w = '0;
        for (int i = 0; i < nb; i++) begin
            b = (i < L) ? mw[L-1-i] : 1'b1;
            if (!cpha) begin
                bus.MOSI = b;
                wclk(H);
                if (i < L) miso_w = {miso_w[30:0], bus.MISO};
                bus.SPI_SCLK = ~cpol;
                wclk(H);
                bus.SPI_SCLK = cpol;
            end else begin
                bus.SPI_SCLK = ~cpol;
                bus.MOSI     = b;
                wclk(H);
                if (i < L) miso_w = {miso_w[30:0], bus.MISO};
                bus.SPI_SCLK = cpol;
                wclk(H);
            end
        end
    endtask

    initial begin
        tbl[0] = '{0, 2'd0, 1'b0, 1'b0, 32'h0000_00A5, 32'h0000_003C, 32'h0000_00A5, 32'h0000_003C};
        tbl[1] = '{1, 2'd3, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678};
        tbl[2] = '{0, 2'd1, 1'b0, 1'b1, 32'h0000_1234, 32'hFFFF_ABCD, 32'h0000_1234, 32'h0000_ABCD};
        tbl[3] = '{1, 2'd2, 1'b1, 1'b0, 32'h00C0_FFEE, 32'hAA5A_A50F, 32'h00C0_FFEE, 32'h005A_A50F};

        rst                    = 1'b0;
        bus.CS                 = '1;
        bus.SPI_SCLK           = 1'b0;
        bus.MOSI               = 1'b0;
        bus.CPOL               = 1'b0;
        bus.CPHA               = 1'b0;
        bus.transaction_length = 2'd0;
        bus.tx_data            = '0;
        wclk(5);
        chk("reset_rx_data0", bus.rx_data[31:0], 32'h0);
        chk("reset_rx_data1", bus.rx_data[63:32], 32'h0);
        chk("reset_rx_valid", 32'(bus.rx_valid), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_abort", 32'(bus.abort), 32'h0);
        chk("reset_collision", 32'(bus.collision), 32'h0);
        chk("reset_miso", 32'(bus.MISO), 32'h0);
        rst = 1'b1;
        wclk(4);
        exp_rx[0] = '0;
        exp_rx[1] = '0;

        for (int k = 0; k < 4; k++) begin
            int L, oth;
            L   = 8 * (int'(tbl[k].len) + 1);
            oth = 1 - tbl[k].ch;
            if (tbl[k].ch == 0) setup(tbl[k].cpol, tbl[k].cpha, tbl[k].len, tbl[k].tx, 32'h5555_5555);
            else                setup(tbl[k].cpol, tbl[k].cpha, tbl[k].len, 32'h5555_5555, tbl[k].tx);
            snap();
            bus.CS = (tbl[k].ch == 0) ? 2'b10 : 2'b01;
            wclk(H);
            chk($sformatf("v%0d_busy_mid", k), 32'(bus.busy), 32'h1);
            bus.transaction_length = ~tbl[k].len;
            bus.CPOL               = ~tbl[k].cpol;
            bus.CPHA               = ~tbl[k].cpha;
            bus.tx_data            = ~bus.tx_data;
            xfer(tbl[k].cpol, tbl[k].cpha, L, L, tbl[k].mosi, sw);
            wclk(H);
            bus.CS = '1;
            wclk(6);
            chk($sformatf("v%0d_rx_data", k), bus.rx_data[32*tbl[k].ch +: 32], tbl[k].exp_rx);
            chk($sformatf("v%0d_rx_other", k), bus.rx_data[32*oth +: 32], exp_rx[oth]);
            chk($sformatf("v%0d_miso", k), sw, tbl[k].exp_miso);
            chk($sformatf("v%0d_rv_pulses", k), 32'(tbl[k].ch == 0 ? rv0 - s0 : rv1 - s1), 32'd1);
            chk($sformatf("v%0d_rv_other", k), 32'(tbl[k].ch == 0 ? rv1 - s1 : rv0 - s0), 32'd0);
            chk($sformatf("v%0d_abort", k), 32'(abc - sa), 32'd0);
            chk($sformatf("v%0d_busy_end", k), 32'(bus.busy), 32'h0);
            exp_rx[tbl[k].ch] = tbl[k].exp_rx;
        end

        // Incomplete frame: CS released after 9 of 16 bits.
        setup(1'b0, 1'b1, 2'd1, 32'h0000_BEEF, 32'h0);
        snap();
        bus.CS = 2'b10;
        wclk(H);
        xfer(1'b0, 1'b1, 16, 9, 32'h0000_F00D, sw);
        wclk(2);
        bus.CS = '1;
        wclk(8);
        chk("abort_pulses", 32'(abc - sa), 32'd1);
        chk("abort_no_rv", 32'(rv0 - s0), 32'd0);
        chk("abort_rx_data0", bus.rx_data[31:0], exp_rx[0]);
        chk("abort_busy", 32'(bus.busy), 32'h0);

        // Second chip select drops mid-frame.
        setup(1'b0, 1'b0, 2'd0, 32'h0000_00FF, 32'h0000_00FF);
        snap();
        bus.CS = 2'b10;
        wclk(H);
        xfer(1'b0, 1'b0, 8, 3, 32'h0000_00FF, sw);
        bus.CS = 2'b00;
        wclk(2);
        chk("coll_high", 32'(bus.collision), 32'h1);
        chk("coll_miso", 32'(bus.MISO), 32'h0);
        wclk(2);
        chk("coll_busy", 32'(bus.busy), 32'h0);
        wclk(10);
        chk("coll_no_start", 32'(bus.busy), 32'h0);
        bus.CS = '1;
        wclk(4);
        chk("coll_low", 32'(bus.collision), 32'h0);
        chk("coll_abort", 32'(abc - sa), 32'd1);
        chk("coll_no_rv", 32'(rv0 - s0 + rv1 - s1), 32'd0);

        // Reset after 12 of 16 bits, then a clean frame.
        setup(1'b0, 1'b0, 2'd1, 32'h0, 32'h0000_0F0F);
        snap();
        bus.CS = 2'b01;
        wclk(H);
        xfer(1'b0, 1'b0, 16, 12, 32'h0000_BEEF, sw);
        rst    = 1'b0;
        bus.CS = '1;
        wclk(1);
        chk("rst_rx_data0", bus.rx_data[31:0], 32'h0);
        chk("rst_rx_data1", bus.rx_data[63:32], 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_miso", 32'(bus.MISO), 32'h0);
        chk("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
        wclk(3);
        rst = 1'b1;
        wclk(4);
        chk("rst_no_pulses", 32'(rv0 - s0 + rv1 - s1 + abc - sa), 32'd0);
        exp_rx[0] = '0;
        exp_rx[1] = '0;
        snap();
        bus.CS = 2'b01;
        wclk(H);
        xfer(1'b0, 1'b0, 16, 16, 32'h0000_BEEF, sw);
        wclk(H);
        bus.CS = '1;
        wclk(6);
        chk("post_rst_rx1", bus.rx_data[63:32], 32'h0000_BEEF);
        chk("post_rst_rx0", bus.rx_data[31:0], 32'h0);
        chk("post_rst_miso", sw, 32'h0000_0F0F);
        chk("post_rst_rv", 32'(rv1 - s1), 32'd1);

        // Eight extra SCLK cycles after an 8-bit frame before CS release.
        setup(1'b0, 1'b0, 2'd0, 32'h0000_00C3, 32'h0);
        snap();
        bus.CS = 2'b10;
        wclk(H);
        xfer(1'b0, 1'b0, 8, 16, 32'h0000_0081, sw);
        wclk(H);
        bus.CS = '1;
        wclk(6);
        chk("extra_rx0", bus.rx_data[31:0], 32'h0000_0081);
        chk("extra_rv", 32'(rv0 - s0), 32'd1);
        chk("extra_miso", sw, 32'h0000_00C3);
        chk("extra_rx1", bus.rx_data[63:32], 32'h0000_BEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_slave_array.md
SPI_SLAVE_ARRAY -- requirements
Module: spi_slave_array

Interface
REQ-001 Parameter CH, default 2: number of slave channels (one chip select each), 1..8.
REQ-002 Parameter SYNC_STAGES, default 2: synchroniser depth for all SPI pins, 2..4.
REQ-003 clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 SPI_SCLK  input  1  SPI serial clock from external master, asynchronous to clk.
REQ-006 MOSI  input  1  master-out serial data.
REQ-007 MISO  output  1  slave-out serial data, driven by the selected channel.
REQ-008 CS  input  CH  active-low chip selects, bit i selects channel i.
REQ-009 transaction_length  input  2  frame length select: 0=8, 1=16, 2=24, 3=32 bits.
REQ-010 CPOL  input  1  SCLK idle level.
REQ-011 CPHA  input  1  0: sample on leading edge; 1: sample on trailing edge.
REQ-012 tx_data  input  CH*32  transmit word per channel, channel i at bits [32i+31:32i].
REQ-013 rx_data  output  CH*32  last complete received word per channel, same packing.
REQ-014 rx_valid  output  CH  one-cycle pulse per channel on frame completion.
REQ-015 busy  output  1  high while a frame is in progress (states SHIFT, DONE).
REQ-016 abort  output  1  one-cycle pulse when a frame ends incomplete.
REQ-017 collision  output  1  high while more than one synchronised CS bit is low.

Function
REQ-018 SPI_SCLK, MOSI and CS SHALL each pass through SYNC_STAGES flops; all decisions use synchronised values; SCLK edges are one-cycle pulses from synchronised-value compare.
REQ-019 Leading edge = synchronised SCLK leaving CPOL level; trailing edge = returning to CPOL level.
REQ-020 FSM states IDLE, SHIFT, DONE; reset state IDLE.
REQ-021 IDLE->SHIFT when exactly one synchronised CS bit is low: latch channel index, L=8*(transaction_length+1), CPOL, CPHA; load tx shifter with tx_data[idx][L-1:0]; clear bit counter and rx shifter.
REQ-022 Latched mode/length SHALL hold for the whole frame; input changes mid-frame have no effect.
REQ-023 Data MSB first; on sample edge rx shifter shifts in MOSI and bit counter increments.
REQ-024 CPHA=0: MISO shows bit L-1 from the cycle SHIFT is entered; advances to next bit on each trailing edge.
REQ-025 CPHA=1: MISO advances to next bit on each leading edge, first leading edge presents bit L-1.
REQ-026 When bit counter reaches L: in the next cycle rx_data[idx] <= received L bits zero-extended to 32, rx_valid[idx] pulses, state -> DONE.
REQ-027 DONE: further SCLK edges ignored, MISO=0; -> IDLE when selected CS bit returns high.
REQ-028 Selected CS high in SHIFT before L bits: abort pulses, rx_data unchanged, no rx_valid, -> IDLE.
REQ-029 collision high in SHIFT: abort pulses, -> IDLE; IDLE SHALL NOT start a frame while collision is high.
REQ-030 MISO SHALL be 0 in IDLE, DONE, and whenever collision is high.
REQ-031 Other channels' rx_data SHALL never change during a frame on channel idx.

Reset
REQ-032 While rst=0 at a clk edge: state IDLE, rx_data all 0, rx_valid 0, busy 0, abort 0, collision 0, MISO 0, synchronisers cleared to idle (SCLK=CPOL, CS all 1, MOSI 0).
REQ-033 Reset mid-frame SHALL discard the frame without rx_valid or abort; first frame after release requires a fresh CS falling edge.

Verification
REQ-034 CH=2, mode 0, length 0, CS[0] low, MOSI 0xA5, tx_data[0]=0x3C -> MISO yields 0x3C, rx_data[0]=0x000000A5, rx_valid=2'b01 one cycle.
REQ-035 Mode 3, length 3, CS[1], MOSI 0xDEADBEEF, tx_data[1]=0x12345678 -> MISO 0x12345678, rx_data[1]=0xDEADBEEF, rx_data[0] unchanged.
REQ-036 Mode 1, length 1, CS[0] released after 9 bits -> abort one cycle, rx_valid 0, rx_data[0] unchanged, busy 0 afterwards.
REQ-037 CS=2'b00 mid-frame -> collision 1, abort pulse, MISO 0; CS=2'b11 -> collision 0.
REQ-038 rst=0 after 12 of 16 bits -> all outputs at reset values, no pulses; next full frame received correctly.
REQ-039 Extra 8 SCLK cycles after 8-bit frame before CS release -> single rx_valid, rx_data unchanged by extra edges.
